// File: rtl/clock_divider_bank.sv
// clock_divider_bank: multi-channel integer clock divider with glitch-free staged divisor/enable updates
// and a global sync that phase-aligns every channel.
module clock_divider_bank #(
   parameter int NUM_CH = 2,
   parameter int DIV_W  = 8,
   parameter int CH_W   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr,
   input  logic [CH_W-1:0]         wr_ch,
   input  logic [DIV_W-1:0]        wr_div,
   input  logic                    wr_en,
   input  logic                    sync,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       pending,
   output logic [NUM_CH*DIV_W-1:0] div_reg
);
   genvar c;
   for (c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, sdiv_q, sdiv_d;
      logic             en_q, en_d, sen_q, sen_d, pend_q, pend_d, out_q, tick_q;
      logic             hit, apply;
      logic [DIV_W:0]   high;
      assign hit    = wr && (wr_ch == CH_W'(c));
      // A disabled channel is always at a boundary, so its updates land on the next edge.
      assign apply  = sync || !en_q || (cnt_q == div_q);
      assign sdiv_d = hit ? wr_div : sdiv_q;
      assign sen_d  = hit ? wr_en : sen_q;
      assign div_d  = (apply && (hit || pend_q)) ? sdiv_d : div_q;
      assign en_d   = (apply && (hit || pend_q)) ? sen_d : en_q;
      assign cnt_d  = apply ? '0 : cnt_q + 1'b1;
      assign pend_d = !apply && (pend_q || hit);
      assign high   = ({1'b0, div_d} + (DIV_W+1)'(2)) >> 1;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= '0;
            sdiv_q <= '0;
            en_q   <= 1'b0;
            sen_q  <= 1'b0;
            pend_q <= 1'b0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            sdiv_q <= sdiv_d;
            en_q   <= en_d;
            sen_q  <= sen_d;
            pend_q <= pend_d;
            out_q  <= en_d && ({1'b0, cnt_d} < high);
            tick_q <= en_d && (cnt_d == div_d);
         end
      end
      assign clk_out[c]                = out_q;
      assign tick[c]                   = tick_q;
      assign pending[c]                = pend_q;
      assign div_reg[c*DIV_W +: DIV_W] = div_q;
   end
endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: directed plus random writes/syncs checked against a period/phase model of each channel.
module tb_clock_divider_bank;
   localparam int NUM_CH = 2;
   localparam int DIV_W  = 8;
   localparam int CH_W   = 2;
   logic clk = 1'b0, rst_n = 1'b0, wr = 1'b0, wr_en = 1'b0, sync = 1'b0;
   logic [CH_W-1:0]         wr_ch = '0;
   logic [DIV_W-1:0]        wr_div = '0;
   logic [NUM_CH-1:0]       clk_out, tick, pending;
   logic [NUM_CH*DIV_W-1:0] div_reg;
   int n_cmp = 0, n_err = 0;
   int m_per[NUM_CH], m_ph[NUM_CH], m_stg[NUM_CH];
   bit m_en[NUM_CH], m_sen[NUM_CH], m_pend[NUM_CH];

   always #5 clk = ~clk;

   clock_divider_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
      .clk(clk), .rst_n(rst_n), .wr(wr), .wr_ch(wr_ch), .wr_div(wr_div), .wr_en(wr_en),
      .sync(sync), .clk_out(clk_out), .tick(tick), .pending(pending), .div_reg(div_reg)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_per[c] = 1; m_ph[c] = 0; m_stg[c] = 1;
         m_en[c] = 0; m_sen[c] = 0; m_pend[c] = 0;
      end
   endfunction

   // One clock edge: a channel picks up new settings only at the end of its period, while disabled, or on sync.
   function automatic void model_edge();
      for (int c = 0; c < NUM_CH; c++) begin
         bit hit = wr && (int'(wr_ch) == c);
         if (sync || !m_en[c] || m_ph[c] == m_per[c] - 1) begin
            if (hit) begin
               m_per[c] = int'(wr_div) + 1; m_en[c] = wr_en;
            end else if (m_pend[c]) begin
               m_per[c] = m_stg[c]; m_en[c] = m_sen[c];
            end
            m_ph[c] = 0; m_pend[c] = 0;
         end else begin
            m_ph[c]++;
            if (hit) begin
               m_stg[c] = int'(wr_div) + 1; m_sen[c] = wr_en; m_pend[c] = 1;
            end
         end
      end
   endfunction

   task automatic compare_all();
      logic [NUM_CH-1:0]       e_clk, e_tick, e_pend;
      logic [NUM_CH*DIV_W-1:0] e_div;
      for (int c = 0; c < NUM_CH; c++) begin
         e_clk[c]  = m_en[c] && (m_ph[c] < (m_per[c] + 1) / 2);
         e_tick[c] = m_en[c] && (m_ph[c] == m_per[c] - 1);
         e_pend[c] = m_pend[c];
         e_div[c*DIV_W +: DIV_W] = DIV_W'(m_per[c] - 1);
      end
      check("clk_out", 64'(clk_out), 64'(e_clk));
      check("tick", 64'(tick), 64'(e_tick));
      check("pending", 64'(pending), 64'(e_pend));
      check("div_reg", 64'(div_reg), 64'(e_div));
   endtask

   task automatic step(input bit w, input int ch, input int d, input bit e, input bit s);
      wr = w; wr_ch = CH_W'(ch); wr_div = DIV_W'(d); wr_en = e; sync = s;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      wr = 1'b0; sync = 1'b0;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic random_steps(input int n);
      for (int i = 0; i < n; i++) begin
         int d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
         step($urandom_range(0, 5) == 0, int'($urandom_range(0, 3)), d,
              $urandom_range(0, 4) != 0, $urandom_range(0, 40) == 0);
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("clk_out_in_reset", 64'(clk_out), 64'd0);
      rst_n = 1'b1;
      compare_all();
      step(1, 0, 3, 1, 0);
      idle(8);
      step(1, 1, 4, 1, 0);
      idle(10);
      step(1, 1, 0, 1, 0);
      idle(6);
      step(1, 0, 1, 1, 0);
      idle(6);
      step(1, 0, 5, 1, 0);
      step(1, 1, 2, 1, 0);
      idle(7);
      step(0, 0, 0, 0, 1);
      idle(8);
      step(1, 3, 9, 1, 0);
      idle(4);
      step(1, 0, 7, 0, 0);
      idle(6);
      random_steps(3000);
      // Both channels freshly synced to a long period, so clk_out is high when reset lands mid-cycle.
      step(1, 0, 9, 1, 1);
      step(1, 1, 9, 1, 1);
      @(posedge clk);
      model_edge();
      #2 rst_n = 1'b0;
      #1;
      check("async_clk_out", 64'(clk_out), 64'd0);
      check("async_tick", 64'(tick), 64'd0);
      check("async_pending", 64'(pending), 64'd0);
      check("async_div_reg", 64'(div_reg), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      compare_all();
      random_steps(500);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
